process1_monitor_ctrl: RTL and testbench
========================================

// Module: process1_monitor_ctrl
// PURPOSE
//  Sequencer for the process1_monitor ring-oscillator block. It latches one measurement
//  request, programs target/use_ro and toggles enable for 2**avg_log2 back-to-back runs.
//  It accumulates the 14 RO counts per run and exposes averaged results through a read port.
//  Sits between the CSR/APB slave (req/rd side) and the monitor macro (pm_* side).
// PARAMETERS
//  NB_MON        14     number of ring oscillators (monitor count outputs)
//  COUNT_W       16     monitor count width
//  TARGET_W      4      monitor target field width
//  MAX_AVG_LOG2  3      max log2 of runs per request; accumulator = COUNT_W+MAX_AVG_LOG2 bits
//  SETUP_CYCLES  2      enable-low cycles with settings stable before first run (>=2)
//  GAP_CYCLES    4      enable-low cycles between runs; resets monitor (>=2)
//  TIMEOUT_W     20     run watchdog width; timeout at 2**TIMEOUT_W-1 cycles in RUN
// PORTS
//  clock         in   1                   block clock (same clock as monitor 'clock')
//  rst           in   1                   synchronous, active-high reset
//  start         in   1                   request pulse; accepted only in IDLE
//  cfg_target    in   TARGET_W            monitor target, sampled at accepted start
//  cfg_use_ro    in   NB_MON              RO enable mask, sampled at accepted start
//  cfg_avg_log2  in   $clog2(MAX_AVG_LOG2+1)  runs = 2**min(cfg,MAX_AVG_LOG2), sampled at start
//  busy          out  1                   request in progress
//  done          out  1                   1-cycle pulse, request finished (ok or timeout)
//  err_timeout   out  1                   last request hit watchdog; sticky until next start
//  rd_idx        in   $clog2(NB_MON)      result select
//  rd_data       out  COUNT_W             averaged count of RO rd_idx (combinational)
//  pm_enable     out  1                   to monitor enable
//  pm_target     out  TARGET_W            to monitor target (registered, stable whole request)
//  pm_use_ro     out  NB_MON              to monitor use_ro (registered, stable whole request)
//  pm_valid      in   1                   from monitor valid (clock domain)
//  pm_count      in   NB_MON*COUNT_W      from monitor counts, RO i at [i*COUNT_W +: COUNT_W]
// BEHAVIOUR
//  Reset: FSM=IDLE; busy=done=err_timeout=pm_enable=0; pm_target=pm_use_ro=0.
//   All accumulators=0, so rd_data=0. rst mid-request aborts immediately with no done pulse.
//  FSM IDLE->SETUP->RUN->CAPT->GAP->(RUN | FIN)->IDLE.
//  IDLE: start=1 latches cfg_*, clears accumulators, sample_cnt and err_timeout; next=SETUP.
//  SETUP: pm_enable=0 for SETUP_CYCLES; pm_target/pm_use_ro already driven; next=RUN.
//  RUN: pm_enable=1. Watchdog counts from 0 each RUN entry. pm_valid=1 -> CAPT.
//   Watchdog==max with pm_valid=0 -> err_timeout=1, accumulators cleared, ->GAP, then FIN.
//   pm_valid and watchdog max in the same cycle: pm_valid wins, no error.
//  CAPT (1 cycle, pm_enable still 1): acc[i] += pm_count[i] if use bit i set, else += 0.
//   pm_count is sampled only in this cycle, never outside valid.
//  GAP: pm_enable=0 for GAP_CYCLES. If err or sample_cnt==runs-1 ->FIN, else sample_cnt++ ->RUN.
//  FIN: done=1 for exactly this cycle; busy still 1; next=IDLE. start in FIN is ignored.
//  busy=1 in every state except IDLE; start while busy is dropped (no queue).
//  rd_data = acc[rd_idx] >> avg_log2_latched, truncated to COUNT_W; rd_idx>=NB_MON -> 0.
//   Valid from FIN until next accepted start. The accumulator width guarantees no overflow.
//  pm_enable is driven from a flop (glitch-free); min low time between runs = GAP_CYCLES.
//  Latency, avg_log2=0, no timeout: start -> done =
//   1+SETUP_CYCLES+T_run+1+GAP_CYCLES+1, where T_run = RUN cycles until pm_valid.
// TESTING
//  1 avg=0, use=all, model valid after 40 cycles, counts i*100
//    -> one enable pulse, done once, rd_data(i)=i*100, err=0.
//  2 avg=2, counts 1000,1001,1002,1003 on runs 0..3 -> 4 enable pulses,
//    each low gap >=GAP_CYCLES, rd_data=1001 (4006>>2).
//  3 use=14'h0005, counts all 0xFFFF, avg=3 -> rd_data(0)=rd_data(2)=0xFFFF, others 0,
//    no overflow.
//  4 pm_valid never asserted, TIMEOUT_W=6 -> err_timeout=1 after 63 RUN cycles,
//    done pulse, rd_data=0; next start clears err.
//  5 start while busy, start in FIN cycle, and rst during RUN -> starts ignored;
//    rst gives pm_enable=0, busy=0, no done.
//  6 pm_valid in the exact watchdog-max cycle -> result captured, err_timeout=0;
//    rd_idx=14 -> rd_data=0.

Source files
------------

// File: rtl/process1_monitor_ctrl.sv
// Sequencer for the process1_monitor ring-oscillator macro: runs 2**avg_log2 measurements
// per request, accumulates per-RO counts and serves averaged results on a read port.
module process1_monitor_ctrl #(
   parameter int NB_MON       = 14,
   parameter int COUNT_W      = 16,
   parameter int TARGET_W     = 4,
   parameter int MAX_AVG_LOG2 = 3,
   parameter int SETUP_CYCLES = 2,
   parameter int GAP_CYCLES   = 4,
   parameter int TIMEOUT_W    = 20,
   localparam int AVG_W       = $clog2(MAX_AVG_LOG2 + 1),
   localparam int IDX_W       = $clog2(NB_MON)
) (
   input  logic                      clock,
   input  logic                      rst,
   input  logic                      start,
   input  logic [TARGET_W-1:0]       cfg_target,
   input  logic [NB_MON-1:0]         cfg_use_ro,
   input  logic [AVG_W-1:0]          cfg_avg_log2,
   output logic                      busy,
   output logic                      done,
   output logic                      err_timeout,
   input  logic [IDX_W-1:0]          rd_idx,
   output logic [COUNT_W-1:0]        rd_data,
   output logic                      pm_enable,
   output logic [TARGET_W-1:0]       pm_target,
   output logic [NB_MON-1:0]         pm_use_ro,
   input  logic                      pm_valid,
   input  logic [NB_MON*COUNT_W-1:0] pm_count
);

   localparam int ACC_W = COUNT_W + MAX_AVG_LOG2;
   localparam int SC_W  = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
   localparam int PH_W  = $clog2((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_CAPT  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_FIN   = 3'd5;

   localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
   localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYCLES - 1);
   localparam logic [AVG_W-1:0] AVG_MAX    = AVG_W'(MAX_AVG_LOG2);

   logic [2:0]          state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic [SC_W-1:0]     sc_q, sc_d;
   logic                err_q, err_d;
   logic                en_q, en_d;
   logic [TARGET_W-1:0] tgt_q, tgt_d;
   logic [NB_MON-1:0]   use_q, use_d;
   logic [AVG_W-1:0]    avg_q, avg_d;
   logic                acc_clr, acc_add;
   logic [ACC_W-1:0]    acc_q [NB_MON];
   logic [SC_W:0]       runs_m1;
   logic [ACC_W-1:0]    rd_sh;

   assign runs_m1 = ((SC_W+1)'(1) << avg_q) - (SC_W+1)'(1);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      wd_d    = wd_q;
      sc_d    = sc_q;
      err_d   = err_q;
      tgt_d   = tgt_q;
      use_d   = use_q;
      avg_d   = avg_q;
      acc_clr = 1'b0;
      acc_add = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            tgt_d   = cfg_target;
            use_d   = cfg_use_ro;
            avg_d   = (cfg_avg_log2 > AVG_MAX) ? AVG_MAX : cfg_avg_log2;
            acc_clr = 1'b1;
            sc_d    = '0;
            err_d   = 1'b0;
            phase_d = '0;
            state_d = S_SETUP;
         end
         S_SETUP: if (phase_q == SETUP_LAST) begin
            phase_d = '0;
            wd_d    = '0;
            state_d = S_RUN;
         end else phase_d = phase_q + 1'b1;
         // A valid result in the watchdog's final cycle still counts as a good run.
         S_RUN: if (pm_valid) state_d = S_CAPT;
         else if (wd_q == '1) begin
            err_d   = 1'b1;
            acc_clr = 1'b1;
            phase_d = '0;
            state_d = S_GAP;
         end else wd_d = wd_q + 1'b1;
         S_CAPT: begin
            acc_add = 1'b1;
            phase_d = '0;
            state_d = S_GAP;
         end
         S_GAP: if (phase_q == GAP_LAST) begin
            if (err_q || (sc_q == runs_m1[SC_W-1:0])) state_d = S_FIN;
            else begin
               sc_d    = sc_q + 1'b1;
               wd_d    = '0;
               state_d = S_RUN;
            end
         end else phase_d = phase_q + 1'b1;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      en_d = (state_d == S_RUN) || (state_d == S_CAPT);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         wd_q    <= '0;
         sc_q    <= '0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
         tgt_q   <= '0;
         use_q   <= '0;
         avg_q   <= '0;
         for (int i = 0; i < NB_MON; i++) acc_q[i] <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         wd_q    <= wd_d;
         sc_q    <= sc_d;
         err_q   <= err_d;
         en_q    <= en_d;
         tgt_q   <= tgt_d;
         use_q   <= use_d;
         avg_q   <= avg_d;
         for (int i = 0; i < NB_MON; i++) begin
            if (acc_clr) acc_q[i] <= '0;
            else if (acc_add && use_q[i])
               acc_q[i] <= acc_q[i] + ACC_W'(pm_count[i*COUNT_W +: COUNT_W]);
         end
      end
   end

   always_comb begin
      rd_sh = '0;
      if (int'(rd_idx) < NB_MON) rd_sh = acc_q[rd_idx] >> avg_q;
      rd_data = rd_sh[COUNT_W-1:0];
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FIN);
   assign err_timeout = err_q;
   assign pm_enable   = en_q;
   assign pm_target   = tgt_q;
   assign pm_use_ro   = use_q;

endmodule

// File: tb/tb_process1_monitor_ctrl.sv
// Bench for process1_monitor_ctrl: behavioural monitor model plus a queue of expected
// averaged results filled when each request is issued and drained after done.
module tb_process1_monitor_ctrl;
   localparam int NB = 14, CW = 16, TW = 6, SETUP = 2, GAP = 4;

   logic clock = 1'b0, rst = 1'b1, start = 1'b0;
   logic [3:0] cfg_target = '0;
   logic [13:0] cfg_use_ro = '0;
   logic [1:0] cfg_avg_log2 = '0;
   logic busy, done, err_timeout, pm_enable, pm_valid;
   logic [3:0] rd_idx = '0;
   logic [15:0] rd_data;
   logic [3:0] pm_target;
   logic [13:0] pm_use_ro;
   logic [NB*CW-1:0] pm_count;

   process1_monitor_ctrl #(.TIMEOUT_W(TW)) dut (
      .clock(clock), .rst(rst), .start(start), .cfg_target(cfg_target),
      .cfg_use_ro(cfg_use_ro), .cfg_avg_log2(cfg_avg_log2), .busy(busy), .done(done),
      .err_timeout(err_timeout), .rd_idx(rd_idx), .rd_data(rd_data), .pm_enable(pm_enable),
      .pm_target(pm_target), .pm_use_ro(pm_use_ro), .pm_valid(pm_valid), .pm_count(pm_count));

   always #5 clock = ~clock;

   int vectors = 0, miscompares = 0;
   int exp_q[$];

   // monitor model: valid rises in the valid_after-th enable cycle and holds until enable drops
   logic [15:0] cnt_tab [8][NB];
   int valid_after = 0;
   logic stat_clr = 1'b0;
   int en_cnt, run_idx, pulses, low_run, min_gap, done_cnt, en_cyc;
   logic en_prev;

   assign pm_valid = pm_enable && (valid_after != 0) && (en_cnt >= valid_after - 1);
   always_comb
      for (int i = 0; i < NB; i++)
         pm_count[i*CW +: CW] = pm_valid ? cnt_tab[run_idx & 7][i] : 16'hA5A5;

   always @(posedge clock) begin
      if (stat_clr) begin
         en_cnt <= 0; run_idx <= 0; pulses <= 0; low_run <= 0; min_gap <= 1000;
         done_cnt <= 0; en_cyc <= 0; en_prev <= 1'b0;
      end else begin
         en_cnt  <= pm_enable ? en_cnt + 1 : 0;
         en_prev <= pm_enable;
         low_run <= pm_enable ? 0 : low_run + 1;
         if (pm_enable) en_cyc <= en_cyc + 1;
         if (pm_enable && !en_prev) begin
            pulses <= pulses + 1;
            if (pulses > 0 && low_run < min_gap) min_gap <= low_run;
         end
         if (en_prev && !pm_enable) run_idx <= run_idx + 1;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic fill(input int mode);
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < NB; i++)
            case (mode)
               0: cnt_tab[r][i] = 16'(i * 100);
               1: cnt_tab[r][i] = 16'(1000 + r + 10 * i);
               2: cnt_tab[r][i] = 16'hFFFF;
               default: cnt_tab[r][i] = 16'(i * 7 + 3);
            endcase
   endtask

   task automatic run_req(input logic [3:0] tg, input logic [13:0] um, input logic [1:0] avg,
                          input int va, output int lat, output bit ok);
      @(negedge clock); stat_clr = 1'b1; valid_after = va;
      @(negedge clock); stat_clr = 1'b0;
      cfg_target = tg; cfg_use_ro = um; cfg_avg_log2 = avg; start = 1'b1;
      @(negedge clock); start = 1'b0; cfg_target = ~tg; cfg_use_ro = ~um;
      lat = 1; ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (done) begin ok = 1'b1; break; end
         if (lat == 3) begin
            vectors++;
            if (pm_target !== tg || pm_use_ro !== um || err_timeout !== 1'b0 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL req_setup: tgt=%h use=%h err=%b busy=%b want tgt=%h use=%h err=0 busy=1",
                        pm_target, pm_use_ro, err_timeout, busy, tg, um);
            end
         end
         @(negedge clock); lat++;
      end
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL done_timeout: no done within bound"); end
   endtask

   task automatic check_results(input string nm);
      int e;
      for (int i = 0; i < NB; i++) begin
         rd_idx = 4'(i); #1;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++; $display("FAIL %s: scoreboard empty at idx %0d", nm, i);
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== 16'(e)) begin
               miscompares++;
               $display("FAIL %s rd[%0d]: got %0d want %0d", nm, i, rd_data, e);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; repeat (3) @(negedge clock);
      vectors++;
      if ({busy, done, err_timeout, pm_enable} !== 4'b0 || pm_target !== 4'h0 || pm_use_ro !== 14'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b tgt=%h use=%h want all 0",
                  busy, done, err_timeout, pm_enable, pm_target, pm_use_ro);
      end
      rst = 1'b0;
      for (int i = 0; i < NB; i++) exp_q.push_back(0);
      check_results("reset");
   endtask

   task automatic test_single();
      int lat; bit ok;
      fill(0);
      for (int i = 0; i < NB; i++) exp_q.push_back(i * 100);
      run_req(4'hA, 14'h3FFF, 2'd0, 40, lat, ok);
      vectors++;
      if (lat + 1 !== 1 + SETUP + 40 + 1 + GAP + 1) begin
         miscompares++; $display("FAIL latency: got %0d want %0d", lat + 1, 1 + SETUP + 40 + 1 + GAP + 1);
      end
      @(negedge clock);
      vectors++;
      if (pulses !== 1 || done_cnt !== 1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL single_stats: pulses=%0d done=%0d busy=%b err=%b want 1 1 0 0",
                  pulses, done_cnt, busy, err_timeout);
      end
      check_results("single");
   endtask

   task automatic test_avg();
      int lat; bit ok;
      fill(1);
      for (int i = 0; i < NB; i++) exp_q.push_back((4006 + 40 * i) >> 2);
      run_req(4'h5, 14'h3FFF, 2'd2, 12, lat, ok);
      @(negedge clock);
      vectors++;
      if (pulses !== 4 || min_gap < GAP || done_cnt !== 1) begin
         miscompares++;
         $display("FAIL avg_pulses: pulses=%0d min_gap=%0d done=%0d want 4 >=%0d 1",
                  pulses, min_gap, done_cnt, GAP);
      end
      check_results("avg4");
   endtask

   task automatic test_mask();
      int lat; bit ok;
      fill(2);
      for (int i = 0; i < NB; i++) exp_q.push_back((i == 0 || i == 2) ? 16'hFFFF : 0);
      run_req(4'h1, 14'h0005, 2'd3, 9, lat, ok);
      @(negedge clock);
      vectors++;
      if (pulses !== 8) begin miscompares++; $display("FAIL mask_pulses: got %0d want 8", pulses); end
      check_results("mask");
   endtask

   task automatic test_timeout();
      int lat; bit ok;
      fill(3);
      for (int i = 0; i < NB; i++) exp_q.push_back(0);
      run_req(4'h7, 14'h3FFF, 2'd0, 0, lat, ok);
      @(negedge clock);
      vectors++;
      if (err_timeout !== 1'b1 || done_cnt !== 1 || en_cyc !== (1 << TW) || pulses !== 1) begin
         miscompares++;
         $display("FAIL timeout: err=%b done=%0d en_cyc=%0d pulses=%0d want 1 1 %0d 1",
                  err_timeout, done_cnt, en_cyc, pulses, 1 << TW);
      end
      check_results("timeout");
   endtask

   task automatic test_valid_at_max();
      int lat; bit ok;
      fill(3);
      for (int i = 0; i < NB; i++) exp_q.push_back(i * 7 + 3);
      run_req(4'h2, 14'h3FFF, 2'd0, 1 << TW, lat, ok);
      @(negedge clock);
      vectors++;
      if (err_timeout !== 1'b0 || done_cnt !== 1) begin
         miscompares++; $display("FAIL valid_at_max: err=%b done=%0d want 0 1", err_timeout, done_cnt);
      end
      check_results("valid_at_max");
      for (int k = 14; k < 16; k++) begin
         rd_idx = 4'(k); #1;
         vectors++;
         if (rd_data !== 16'h0) begin
            miscompares++; $display("FAIL rd_oob[%0d]: got %0d want 0", k, rd_data);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit seen;
      fill(0);
      @(negedge clock); stat_clr = 1'b1; valid_after = 20;
      @(negedge clock); stat_clr = 1'b0;
      cfg_target = 4'h3; cfg_use_ro = 14'h3FFF; cfg_avg_log2 = 2'd0; start = 1'b1;
      @(negedge clock); start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin @(negedge clock); seen = pm_enable; end
      cfg_target = 4'hC; cfg_use_ro = 14'h0001; start = 1'b1;
      @(negedge clock); start = 1'b0;
      vectors++;
      if (!seen || pm_target !== 4'h3 || pm_use_ro !== 14'h3FFF) begin
         miscompares++;
         $display("FAIL busy_start: seen_en=%b tgt=%h use=%h want 1 3 3fff", seen, pm_target, pm_use_ro);
      end
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin seen = done; if (!seen) @(negedge clock); end
      cfg_target = 4'h9; start = 1'b1;
      @(negedge clock); start = 1'b0;
      @(negedge clock);
      vectors++;
      if (!seen || busy !== 1'b0 || done_cnt !== 1 || pulses !== 1 || pm_target !== 4'h3) begin
         miscompares++;
         $display("FAIL fin_start: seen_done=%b busy=%b done=%0d pulses=%0d tgt=%h want 1 0 1 1 3",
                  seen, busy, done_cnt, pulses, pm_target);
      end
      for (int i = 0; i < NB; i++) exp_q.push_back(i * 100);
      check_results("b2b");
   endtask

   task automatic test_rst_mid_run();
      bit seen;
      @(negedge clock); stat_clr = 1'b1; valid_after = 0;
      @(negedge clock); stat_clr = 1'b0;
      cfg_target = 4'hF; cfg_use_ro = 14'h3FFF; start = 1'b1;
      @(negedge clock); start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin @(negedge clock); seen = pm_enable; end
      repeat (5) @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      vectors++;
      if (!seen || pm_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pm_target !== 4'h0) begin
         miscompares++;
         $display("FAIL rst_mid_run: seen_en=%b en=%b busy=%b done=%b tgt=%h want 1 0 0 0 0",
                  seen, pm_enable, busy, done, pm_target);
      end
      rst = 1'b0;
      repeat (100) @(negedge clock);
      vectors++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL rst_no_done: done=%0d busy=%b want 0 0", done_cnt, busy);
      end
   endtask

   initial begin
      fill(0);
      stat_clr = 1'b1;
      test_reset();
      test_single();
      test_avg();
      test_mask();
      test_timeout();
      test_valid_at_max();
      test_back_to_back();
      test_rst_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
